// File: rtl/req_vec_serializer.sv
// req_vec_serializer: captures a multi-hot request vector and emits the index
// of each set bit, lowest first, one beat per out_valid/out_ready handshake.
//
// Parameters:
//   W          width of the request vector (>= 2)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of the vector being drained
//   in_valid   in_vec offered
//   in_ready   block can capture in_vec this cycle
//   in_vec     request vector (zero or more bits set)
//   out_valid  out_idx holds a valid index
//   out_ready  downstream accepts the current index
//   out_idx    index of the lowest pending set bit
//   out_last   current index is the final pending bit
//   out_seq    zero-based beat number within the vector
//
// Build option: define REQ_SER_BYPASS_EN to allow capture of the next vector
// in the last-beat cycle (zero bubbles between vectors). Without it, one IDLE
// cycle separates consecutive vectors.
module req_vec_serializer #(
  parameter int unsigned W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(W)-1:0]   out_idx,
  output logic                   out_last,
  output logic [$clog2(W):0]     out_seq
);

  localparam int unsigned IW = $clog2(W);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   pending, pending_nxt;
  logic [IW:0]    seq_nxt;
  logic           single_bit;

  // Lowest set bit of pending wins.
  always_comb begin
    out_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending[i]) out_idx = IW'(i);
    end
  end

  // pending & (pending - 1) drops the lowest set bit; zero result means one-hot.
  assign single_bit = (pending != '0) && ((pending & (pending - W'(1))) == '0);

  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && single_bit;

  // Capture window; rst_n gating keeps in_ready low while reset is held.
`ifdef REQ_SER_BYPASS_EN
  assign in_ready = rst_n && !flush && ((state == IDLE) || (out_ready && out_last));
`else
  assign in_ready = rst_n && !flush && (state == IDLE);
`endif

  // Next-state and datapath update; capture overrides a same-cycle last beat.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    seq_nxt     = out_seq;
    if (flush) begin
      state_nxt   = IDLE;
      pending_nxt = '0;
      seq_nxt     = '0;
    end else begin
      if (out_valid && out_ready) begin
        pending_nxt = pending & (pending - W'(1));
        seq_nxt     = out_seq + (IW+1)'(1);
        if (out_last) state_nxt = IDLE;
      end
      if (in_valid && in_ready) begin
        pending_nxt = in_vec;
        seq_nxt     = '0;
        state_nxt   = (in_vec != '0) ? DRAIN : IDLE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      out_seq <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      out_seq <= seq_nxt;
    end
  end

endmodule

// File: doc/req_vec_serializer.md
REQ_VEC_SERIALIZER -- requirements
Module: req_vec_serializer

Interface
REQ-001 Parameter W, default 16: width of the request vector; W SHALL be ≥ 2.
REQ-002 Derived localparam IW = $clog2(W): width of the emitted index.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 flush  input  1  synchronous abort of the vector currently being drained.
REQ-006 in_valid  input  1  in_vec is offered.
REQ-007 in_ready  output  1  block can capture in_vec this cycle.
REQ-008 in_vec  input  W  multi-hot request vector; zero or more bits set.
REQ-009 out_valid  output  1  out_idx holds a valid index.
REQ-010 out_ready  input  1  downstream accepts the current index.
REQ-011 out_idx  output  IW  binary index of the lowest set bit still pending.
REQ-012 out_last  output  1  current index is the final set bit of the captured vector.
REQ-013 out_seq  output  IW+1  zero-based beat number of the current index within its vector.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and DRAIN.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In IDLE, if in_valid && in_vec != 0, the block SHALL register in_vec into pending, clear the beat counter, and enter DRAIN.
REQ-017 In IDLE, if in_valid && in_vec == 0, the block SHALL consume the vector, emit no beats, and stay in IDLE.
REQ-018 In DRAIN, out_valid SHALL be 1; out_idx SHALL be the lowest set bit of pending (combinational, lowest index wins).
REQ-019 out_last SHALL be 1 exactly when pending has one bit set.
REQ-020 On out_valid && out_ready, the bit at out_idx SHALL be cleared from pending and out_seq SHALL increment by 1.
REQ-021 On a handshake with out_last=1, the FSM SHALL return to IDLE.
REQ-022 If out_ready is 0, out_idx, out_last and out_seq SHALL hold stable.
REQ-023 First-beat latency: out_valid SHALL assert in the cycle after capture.
REQ-024 A vector with N set bits SHALL produce exactly N beats, in ascending index order.
REQ-025 flush=1 in any state SHALL clear pending and out_seq and force IDLE on the next edge; no beat handshakes in that cycle.
REQ-026 flush SHALL take priority over capture: in_ready SHALL be 0 while flush=1.
REQ-027 Without REQ_SER_BYPASS_EN, in_ready SHALL be 0 throughout DRAIN.

Reset
REQ-028 While rst_n=0: state=IDLE, pending=0, out_seq=0, out_valid=0, out_last=0, out_idx=0, in_ready=0.
REQ-029 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-030 Reset asserted mid-DRAIN SHALL discard all remaining beats immediately, with no partial beat after release.

Configuration
REQ-031 Macro REQ_SER_BYPASS_EN controls back-to-back capture.
REQ-032 When defined: in DRAIN, in_ready = out_ready && out_last && !flush. A capture in the last-beat cycle SHALL load the new vector and keep DRAIN, or go to IDLE if the new vector is 0. This gives zero bubble cycles between vectors.
REQ-033 When undefined: one IDLE cycle SHALL separate consecutive vectors.

Verification
REQ-034 W=16, capture 16'h8421, out_ready=1 -> idx 0,5,10,15; seq 0..3; out_last only on idx 15; IDLE next cycle.
REQ-035 Capture 16'h0000 -> no out_valid; in_ready stays 1; next vector 16'h0002 -> single beat, idx 1, last=1.
REQ-036 Capture 16'h0003, out_ready low 3 cycles -> idx=0, seq=0 held stable; then beats idx 0 and 1.
REQ-037 Capture 16'hFFFF, flush after 2 beats -> IDLE next edge; no further beats; next vector 16'h0100 -> idx 8, seq 0.
REQ-038 rst_n pulsed low mid-DRAIN of 16'h00F0 -> outputs zero immediately; no beats after release.
REQ-039 Vectors 16'h0001 then 16'h0004 offered back-to-back, out_ready=1 -> with REQ_SER_BYPASS_EN: idx 0 then idx 2 on consecutive cycles; without it: one bubble cycle between them.
